fastest_finger_main: RTL and testbench

Four-player "fastest finger first" arbiter with 7-segment winner display. The host arms a round with `en`; the first player button seen while the round is armed is latched as winner and shown as digit 1–4 until the next round is armed or reset. Top-level game block between the raw push-button pins and a single common-cathode 7-segment digit.

---
 rtl/ffm_pkg.sv | 30 +++
 rtl/ffm_sync.sv | 21 ++
 rtl/fastest_finger_main.sv | 96 +++++++++
 tb/tb_fastest_finger_main.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ffm_pkg.sv
// Shared types and segment patterns for the fastest-finger arbiter.
// Segment order is {a,b,c,d,e,f,g}, active-high, common cathode.
package ffm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;

  // Winner index 0..3 maps to the player digit 1..4.
  function automatic logic [6:0] seg_digit(input logic [1:0] w);
    logic [6:0] s;
    case (w)
      2'd0:    s = SEG_1;
      2'd1:    s = SEG_2;
      2'd2:    s = SEG_3;
      default: s = SEG_4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ffm_sync.sv
// Single-bit N-stage synchronizer for an asynchronous input, with
// synchronous active-low clear.
module ffm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/fastest_finger_main.sv
// Four-player first-press arbiter: synchronizes buttons and enable, latches the
// first press of an armed round and drives the winner digit on a 7-seg display.
module fastest_finger_main
  import ffm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       P1,
  input  logic       P2,
  input  logic       P3,
  input  logic       P4,
  input  logic       en,
  output logic [6:0] out
);

  logic [4:0] raw;
  logic [4:0] syn;
  logic [3:0] btn;
  logic       en_s;
  logic       en_q;
  logic       en_rise;
  logic       press;
  logic [1:0] enc;
  logic [1:0] winner, winner_nx;
  state_t     state, state_nx;

  assign raw = {en, P4, P3, P2, P1};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    ffm_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (raw[i]),
      .q     (syn[i])
    );
  end

  assign btn     = syn[3:0];
  assign en_s    = syn[4];
  assign en_rise = en_s & ~en_q;
  assign press   = |btn;

  // Fixed priority: lowest-numbered player wins a same-cycle tie.
  always_comb begin
    enc = 2'd3;
    if      (btn[0]) enc = 2'd0;
    else if (btn[1]) enc = 2'd1;
    else if (btn[2]) enc = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      state  <= IDLE;
      winner <= 2'd0;
    end else begin
      en_q   <= en_s;
      state  <= state_nx;
      winner <= winner_nx;
    end
  end

  // A new round may open and close in the same cycle if a button is already high.
  always_comb begin
    state_nx  = state;
    winner_nx = winner;
    if (en_rise) begin
      winner_nx = press ? enc : 2'd0;
      state_nx  = press ? LOCKED : ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (press) begin
            state_nx  = LOCKED;
            winner_nx = enc;
          end else if (!en_s) begin
            state_nx  = IDLE;
          end
        end
        LOCKED:  state_nx = LOCKED;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      ARMED:   out = SEG_DASH;
      LOCKED:  out = seg_digit(winner);
      default: out = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_fastest_finger_main.sv
// Scoreboard bench for fastest_finger_main: each driven cycle queues the display
// value expected once the inputs have crossed the synchronizer and the FSM.
module tb_fastest_finger_main;

  localparam logic [6:0] X_BLANK = 7'b0000000;
  localparam logic [6:0] X_DASH  = 7'b0000001;
  localparam logic [6:0] X_1     = 7'b0110000;
  localparam logic [6:0] X_2     = 7'b1101101;
  localparam logic [6:0] X_3     = 7'b1111001;
  localparam logic [6:0] X_4     = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       P1 = 1'b0, P2 = 1'b0, P3 = 1'b0, P4 = 1'b0, en = 1'b0;
  logic [6:0] out;

  typedef struct {
    int         due;
    logic [6:0] exp;
    string      tag;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  fastest_finger_main #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .P1    (P1),
    .P2    (P2),
    .P3    (P3),
    .P4    (P4),
    .en    (en),
    .out   (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b expected=%b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; the display reflects them after the third edge.
  task automatic tick(input string tag, input logic e, input logic [3:0] p, input logic [6:0] exp);
    sb_t s;
    @(negedge clk);
    rst_n = 1'b1;
    en = e;
    {P4, P3, P2, P1} = p;
    s.due = cyc + 3;
    s.exp = exp;
    s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic ticks(input int n, input string tag, input logic e, input logic [3:0] p,
                       input logic [6:0] exp);
    for (int i = 0; i < n; i++) tick(tag, e, p, exp);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 7'd1, 7'd0);
  endtask

  always @(posedge clk) begin
    sb_t s;
    #1;
    while (sbq.size() != 0 && sbq[0].due <= cyc) begin
      s = sbq.pop_front();
      if (s.due == cyc) chk(s.tag, out, s.exp);
    end
  end

  initial begin
    // Reset with random inputs for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      {en, P4, P3, P2, P1} = 5'($urandom);
      @(posedge clk);
      #1;
      chk("reset_blank", out, X_BLANK);
    end

    ticks(3, "idle_after_reset", 1'b0, 4'b0000, X_BLANK);
    ticks(3, "armed_dash", 1'b1, 4'b0000, X_DASH);
    tick("p2_wins", 1'b1, 4'b0010, X_2);
    ticks(3, "p1_late_ignored", 1'b1, 4'b0011, X_2);
    ticks(3, "en_low_p3p4_ignored", 1'b0, 4'b1100, X_2);
    ticks(2, "release_hold", 1'b0, 4'b0000, X_2);

    ticks(3, "arm_and_p1_same_cycle", 1'b1, 4'b0001, X_1);

    ticks(2, "p1_hold_en_low", 1'b0, 4'b0000, X_1);
    ticks(2, "new_round_dash", 1'b1, 4'b0000, X_DASH);
    ticks(3, "p4_wins", 1'b1, 4'b1000, X_4);

    ticks(2, "p4_hold_en_low", 1'b0, 4'b0000, X_4);
    ticks(2, "tie_round_dash", 1'b1, 4'b0000, X_DASH);
    ticks(3, "tie_p3_over_p4", 1'b1, 4'b1100, X_3);

    ticks(2, "p3_hold_en_low", 1'b0, 4'b0000, X_3);
    ticks(2, "abort_round_dash", 1'b1, 4'b0000, X_DASH);
    ticks(3, "abort_to_blank", 1'b0, 4'b0000, X_BLANK);
    ticks(2, "idle_press_ignored", 1'b0, 4'b0010, X_BLANK);
    ticks(2, "held_through_arm", 1'b1, 4'b0010, X_2);

    ticks(2, "p2_hold_en_low", 1'b0, 4'b0000, X_2);
    ticks(2, "pre_reset_dash", 1'b1, 4'b0000, X_DASH);
    ticks(3, "pre_reset_p3", 1'b1, 4'b0100, X_3);
    drain();

    // One-clock reset in the middle of a locked round, en kept high.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midround_reset_blank", out, X_BLANK);

    ticks(3, "en_high_at_release_arms", 1'b1, 4'b0000, X_DASH);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
